modport_rd_fifo: RTL and testbench

MODPORT_RD_FIFO -- requirements
Module: modport_rd_fifo

---
 rtl/modport_rd_pkg.sv | 26 ++
 rtl/modport_rd_mem.sv | 37 +++
 rtl/modport_rd_fifo.sv | 113 +++++++++++
 tb/tb_modport_rd_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/modport_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modport_rd_pkg
// Description : Shared definitions for the modport_rd_fifo block: default
//               data width and depth, pointer/count typedefs derived from
//               them, and a power-of-two check on the default depth.
// Revision    : 1.0 - initial release
// ============================================================================
package modport_rd_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 4;

    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = PTR_W_DEF + 1;

    typedef logic [PTR_W_DEF-1:0] ptr_t;
    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Pointers wrap by natural binary overflow, which only works when the
    // depth is a power of two.
    localparam bit DEPTH_IS_POW2 = (DEPTH_DEF >= 2) &&
                                   ((DEPTH_DEF & (DEPTH_DEF - 1)) == 0);

endpackage : modport_rd_pkg
`default_nettype wire

// File: rtl/modport_rd_mem.sv
`default_nettype none
// ============================================================================
// Module      : modport_rd_mem
// Description : FIFO storage array. One synchronous write port, one
//               asynchronous read port. The array is intentionally not reset.
// Ports       : i_clk            - rising-edge clock
//               i_we             - write enable
//               i_waddr/i_wdata  - write address / data
//               i_raddr          - read address
//               o_rdata          - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module modport_rd_mem #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : modport_rd_mem
`default_nettype wire

// File: rtl/modport_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : modport_rd_fifo
// Description : Synchronous FIFO with a writer side (i_en/i_a/o_rdy) and a
//               reader side (i_rd/o_vld/o_a/o_b). Head data is presented in
//               true (o_a) and inverted (o_b) polarity, both forced to zero
//               while empty. o_ovf is a sticky flag set when a write is
//               dropped because the FIFO is full.
// Ports       : i_clk, i_rst (sync, active high)
//               i_en, i_a, o_rdy         - producer side
//               i_rd, o_vld, o_a, o_b    - consumer side
//               o_ovf                    - sticky overflow flag
//               o_level                  - registered count (optional)
// Config      : MODPORT_RD_FIFO_LEVEL_EN - when defined, adds o_level.
// Revision    : 1.0 - initial release
// ============================================================================
module modport_rd_fifo
    import modport_rd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
    output logic             o_rdy,
    input  logic             i_rd,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_ovf
`ifdef MODPORT_RD_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] o_level
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;

    logic               w_rdy;
    logic               w_vld;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_head;

    // Flow control comes from the registered count only, so a pop on the
    // same edge never makes room for a write while full.
    assign w_rdy  = (r_count < c_CNT_MAX);
    assign w_vld  = (r_count != '0);
    assign w_push = i_en & w_rdy;
    assign w_pop  = i_rd & w_vld;

    modport_rd_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (c_PTR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (i_a),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            // Power-of-two depth: pointer overflow is the wrap to zero.
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (i_en && !w_rdy) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_rdy = w_rdy;
    assign o_vld = w_vld;
    assign o_a   = w_vld ? w_head  : '0;
    assign o_b   = w_vld ? ~w_head : '0;
    assign o_ovf = r_ovf;

`ifdef MODPORT_RD_FIFO_LEVEL_EN
    assign o_level = r_count;
`endif

endmodule : modport_rd_fifo
`default_nettype wire

// File: tb/tb_modport_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_modport_rd_fifo
// Description : Self-checking bench for modport_rd_fifo (WIDTH=4, DEPTH=4).
//               A table of {inputs, expected outputs} records is applied one
//               clock edge per record, followed by a pseudo-random push/pop
//               run checked against a queue model.
// Config      : MODPORT_RD_FIFO_LEVEL_EN - also checks o_level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_rd_fifo;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] a;
    logic       rd;
    logic       rdy;
    logic       vld;
    logic [3:0] oa;
    logic [3:0] ob;
    logic       ovf;
`ifdef MODPORT_RD_FIFO_LEVEL_EN
    logic [2:0] level;
`endif

    modport_rd_fifo #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_a     (a),
        .o_rdy   (rdy),
        .i_rd    (rd),
        .o_vld   (vld),
        .o_a     (oa),
        .o_b     (ob),
        .o_ovf   (ovf)
`ifdef MODPORT_RD_FIFO_LEVEL_EN
        ,
        .o_level (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rd;
        logic [3:0] a;
        logic       vld;
        logic       rdy;
        logic [3:0] oa;
        logic       ovf;
        logic [2:0] lvl;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic add(input logic r, input logic e, input logic d, input logic [3:0] ia,
                       input logic xv, input logic xr, input logic [3:0] xa,
                       input logic xo, input logic [2:0] xl);
        vec_t v;
        v.rst = r;  v.en = e;  v.rd = d;  v.a = ia;
        v.vld = xv; v.rdy = xr; v.oa = xa; v.ovf = xo; v.lvl = xl;
        vecs.push_back(v);
    endtask

    // Drive inputs, take one edge, sample 1 time unit later and compare.
    task automatic apply(input int idx, input vec_t v);
        logic [3:0] xb;
        logic       bad;
        rst = v.rst; en = v.en; rd = v.rd; a = v.a;
        @(posedge clk);
        #1;
        xb  = v.vld ? ~v.oa : 4'h0;
        bad = (vld !== v.vld) || (rdy !== v.rdy) || (oa !== v.oa) ||
              (ob !== xb) || (ovf !== v.ovf);
`ifdef MODPORT_RD_FIFO_LEVEL_EN
        if (level !== v.lvl) bad = 1'b1;
`endif
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL vec%0d: got vld=%b rdy=%b a=%h b=%h ovf=%b, expected vld=%b rdy=%b a=%h b=%h ovf=%b lvl=%0d",
                     idx, vld, rdy, oa, ob, ovf, v.vld, v.rdy, v.oa, xb, v.ovf, v.lvl);
        end
    endtask

    initial begin
        logic [3:0] q[$];
        logic       m_ovf;
        logic       x_vld;
        logic       x_rdy;
        logic [3:0] x_a;
        logic [3:0] x_b;
        logic       push;
        logic       pop;

        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; en = 1'b0; rd = 1'b0; a = 4'h0;

        //   rst en rd a      vld rdy oa    ovf lvl
        // Reset state, then single push / pop
        add(1, 0, 0, 4'h0,  0, 1, 4'h0, 0, 0);
        add(0, 1, 0, 4'h5,  1, 1, 4'h5, 0, 1);
        add(0, 0, 1, 4'h0,  0, 1, 4'h0, 0, 0);
        // Fill, overflow drop, drain in order
        add(0, 1, 0, 4'h1,  1, 1, 4'h1, 0, 1);
        add(0, 1, 0, 4'h2,  1, 1, 4'h1, 0, 2);
        add(0, 1, 0, 4'h3,  1, 1, 4'h1, 0, 3);
        add(0, 1, 0, 4'h4,  1, 0, 4'h1, 0, 4);
        add(0, 1, 0, 4'hF,  1, 0, 4'h1, 1, 4);
        add(0, 0, 1, 4'h0,  1, 1, 4'h2, 1, 3);
        add(0, 0, 1, 4'h0,  1, 1, 4'h3, 1, 2);
        add(0, 0, 1, 4'h0,  1, 1, 4'h4, 1, 1);
        add(0, 0, 1, 4'h0,  0, 1, 4'h0, 1, 0);
        // Streaming push+pop: first edge ignores the pop (empty), then
        // count holds at 1 and pointers wrap twice.
        add(1, 0, 0, 4'h0,  0, 1, 4'h0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            add(0, 1, 1, 4'(i), 1, 1, 4'(i), 0, 1);
        end
        add(0, 0, 1, 4'h0,  0, 1, 4'h0, 0, 0);
        // Full with push+pop on one edge: one pop, write rejected
        add(0, 1, 0, 4'h6,  1, 1, 4'h6, 0, 1);
        add(0, 1, 0, 4'h7,  1, 1, 4'h6, 0, 2);
        add(0, 1, 0, 4'h8,  1, 1, 4'h6, 0, 3);
        add(0, 1, 0, 4'h9,  1, 0, 4'h6, 0, 4);
        add(0, 1, 1, 4'hC,  1, 1, 4'h7, 1, 3);
        add(0, 0, 1, 4'h0,  1, 1, 4'h8, 1, 2);
        add(0, 0, 1, 4'h0,  1, 1, 4'h9, 1, 1);
        add(0, 0, 1, 4'h0,  0, 1, 4'h0, 1, 0);
        // Reset during a push with 3 entries stored discards them all
        add(0, 1, 0, 4'h1,  1, 1, 4'h1, 1, 1);
        add(0, 1, 0, 4'h2,  1, 1, 4'h1, 1, 2);
        add(0, 1, 0, 4'h3,  1, 1, 4'h1, 1, 3);
        add(1, 1, 1, 4'h4,  0, 1, 4'h0, 0, 0);
        // Level sequence 1,2,1 after the reset
        add(0, 1, 0, 4'h5,  1, 1, 4'h5, 0, 1);
        add(0, 1, 0, 4'h6,  1, 1, 4'h5, 0, 2);
        add(0, 0, 1, 4'h0,  1, 1, 4'h6, 0, 1);
        add(0, 0, 1, 4'h0,  0, 1, 4'h0, 0, 0);

        foreach (vecs[i]) begin
            apply(i, vecs[i]);
        end

        // Pseudo-random push/pop traffic against a queue model
        rst = 1'b1; en = 1'b0; rd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ovf = 1'b0;
        for (int c = 0; c < 60; c++) begin
            en = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 3) != 0 ? 0 : 1) | ((c % 16) >= 10);
            a  = 4'($urandom_range(0, 15));
            push = en && (q.size() < 4);
            pop  = rd && (q.size() > 0);
            if (en && !push) m_ovf = 1'b1;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(a);
            @(posedge clk);
            #1;
            x_vld = (q.size() > 0);
            x_rdy = (q.size() < 4);
            x_a   = x_vld ? q[0] : 4'h0;
            x_b   = x_vld ? ~q[0] : 4'h0;
            n_vec++;
            if ((vld !== x_vld) || (rdy !== x_rdy) || (oa !== x_a) ||
                (ob !== x_b) || (ovf !== m_ovf)) begin
                n_bad++;
                $display("FAIL rand%0d: got vld=%b rdy=%b a=%h b=%h ovf=%b, expected vld=%b rdy=%b a=%h b=%h ovf=%b",
                         c, vld, rdy, oa, ob, ovf, x_vld, x_rdy, x_a, x_b, m_ovf);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_modport_rd_fifo
`default_nettype wire
